nvram_backup_ctrl: RTL
======================

Name: nvram_backup_ctrl

Overview:
- Parametrised save-RAM backup sequencer for cores with cartridge battery RAM.
- Streams an NVRAM image between the SD image mounted through user_io and the core-side backup dpram, one 512-byte sector at a time.
- Over the fixed 16-sector controller it adds:
  - configurable maximum size;
  - transfer length derived from the image size;
  - dirty tracking;
  - optional idle-timed autosave;
  - a read-only guard;
  - a pending-save latch.
- Sits between user_io sd_* signals and the core top level; drives the dpram port-B upper address.

Parameters:
SECTORS_W, 4, log2 of the maximum sector count (4 gives 16 sectors, 8 KB)
AUTOSAVE_CYCLES, 0, clk_sys idle cycles after the last NVRAM write before an automatic save; 0 disables autosave
TIMER_W, 32, width of the autosave idle counter

Ports:
clk_sys  in  1  system clock; all logic on its rising edge
RESET_n  in  1  asynchronous, active-low reset
img_mounted  in  1  mount strobe from user_io
img_size  in  32  mounted image size in bytes
img_readonly  in  1  image is write-protected
save_req  in  1  manual save; rising edge is the trigger
download  in  1  ROM download active (ioctl_download)
nvram_we  in  1  core write strobe to backup RAM
sd_ack  in  1  user_io sector acknowledge
sd_lba  out  32  sector address
sd_rd  out  1  sector read request
sd_wr  out  1  sector write request
buf_sector  out  SECTORS_W  dpram upper address, equal to sd_lba[SECTORS_W-1:0]
bk_ena  out  1  valid image mounted
busy  out  1  transfer in progress
dirty  out  1  NVRAM modified since the last load or save
bk_reset  out  1  one-cycle core reset pulse after a completed load

Behaviour:
- Reset values:
  - all outputs 0;
  - sd_lba = 0;
  - state IDLE;
  - pending latch, timer and edge registers cleared.
- Edge detection: registered one-cycle-delayed copies of img_mounted, save_req, download and sd_ack.
- Sector count, latched on the rising edge of img_mounted:
  - N = min(ceil(img_size/512), 2^SECTORS_W);
  - last = N-1;
  - img_size == 0 leaves bk_ena = 0 and starts nothing;
  - img_size > 0 sets bk_ena = 1 and starts a load.
- States:
  - IDLE -> START on any of:
    - load trigger;
    - save trigger (manual edge, pending latch, or autosave), only when bk_ena=1 and img_readonly=0.
  - START: sd_lba <= 0; mode <= load/save; dirty <= 0 if save; go REQ.
  - REQ: assert sd_rd (load) or sd_wr (save); go XFER.
  - XFER:
    - on the sd_ack rising edge, clear sd_rd/sd_wr;
    - on the sd_ack falling edge, if sd_lba == last or abort is set, go DONE;
    - otherwise sd_lba <= sd_lba+1 and go REQ.
  - DONE: if load and not aborted, bk_reset = 1 for exactly one cycle; clear abort; go IDLE.
- busy = 1 in every state except IDLE.
- Simultaneous mount edge and save trigger: the load wins and the save is discarded.
- Save trigger while busy: sets the pending latch. It is consumed on the first IDLE cycle, subject to the bk_ena/readonly guards.
- Download rising edge:
  - bk_ena <= 0; pending and dirty cleared;
  - if busy, abort is set. The in-flight sector completes because the host cannot be cancelled; no further requests follow and no bk_reset is issued.
- Dirty tracking:
  - nvram_we with bk_ena=1 and not in a load sets dirty;
  - a write during a save re-sets dirty after the START clear, so the next save is still requested.
- Autosave (AUTOSAVE_CYCLES > 0):
  - timer reloads on every nvram_we and counts down while dirty and IDLE;
  - reaching 0 raises a save trigger once;
  - timer saturates at 0 until it is reloaded.
- sd_lba is always < N; no wrap-around, since the transfer terminates at last.
- RESET_n low mid-transfer: immediate return to reset values; sd_rd/sd_wr drop asynchronously.

Test Plan:
- Mount, img_size=8192, SECTORS_W=4: sd_rd issued 16 times with sd_lba 0..15; buf_sector tracks sd_lba; one bk_reset pulse after the 16th ack falls; busy=0 afterwards.
- Mount, img_size=1500: N=3, sectors 0..2 loaded. Mount, img_size=65536: clamped to 16 sectors. Mount, img_size=0: bk_ena=0 and a later save_req edge produces no sd_wr.
- After a load, nvram_we pulse then save_req edge: dirty=1 before the save; sd_wr on sectors 0..15; dirty=0 at the end; no bk_reset.
- save_req edge at sector 5 of a load: the load completes with bk_reset, then a save starts at sd_lba=0. Same test with img_readonly=1: no save.
- download rises during save sector 7: sector 7 finishes and nothing further is requested; bk_ena=0, busy=0, bk_reset never pulses.
- AUTOSAVE_CYCLES=100: a single nvram_we starts a save 100 cycles later; writes every 50 cycles postpone it indefinitely.

Source files
------------

// File: rtl/nvram_backup_ctrl.sv
// Save-RAM backup sequencer: streams a battery-RAM image between the mounted SD image and the
// core's backup dpram, one 512-byte sector per sd_rd/sd_wr handshake with user_io.
module nvram_backup_ctrl #(
  parameter int unsigned SECTORS_W       = 4,
  parameter int unsigned AUTOSAVE_CYCLES = 0,
  parameter int unsigned TIMER_W         = 32
) (
  input  logic                 clk_sys,
  input  logic                 RESET_n,
  input  logic                 img_mounted,
  input  logic [31:0]          img_size,
  input  logic                 img_readonly,
  input  logic                 save_req,
  input  logic                 download,
  input  logic                 nvram_we,
  input  logic                 sd_ack,
  output logic [31:0]          sd_lba,
  output logic                 sd_rd,
  output logic                 sd_wr,
  output logic [SECTORS_W-1:0] buf_sector,
  output logic                 bk_ena,
  output logic                 busy,
  output logic                 dirty,
  output logic                 bk_reset
);

  localparam int unsigned MaxSectors = 1 << SECTORS_W;

  typedef enum logic [2:0] {StIdle, StStart, StReq, StXfer, StDone} state_e;
  state_e state_q, state_d;

  logic                 mounted_q, save_req_q, download_q, ack_q;
  logic                 mount_rise, save_rise, dl_rise, ack_rise, ack_fall;
  logic [23:0]          img_sectors;
  logic [SECTORS_W-1:0] img_last;
  logic                 img_valid;
  logic [SECTORS_W-1:0] lba_q, lba_d, last_q, last_d;
  logic                 load_mode_q, load_mode_d;
  logic                 abort_q, abort_d;
  logic                 pend_q, pend_d;
  logic                 load_pend_q, load_pend_d;
  logic                 dirty_q, dirty_d;
  logic                 bk_ena_q, bk_ena_d;
  logic                 rd_q, rd_d, wr_q, wr_d;
  logic                 bk_reset_q, bk_reset_d;
  logic [TIMER_W-1:0]   timer_q, timer_d;
  logic                 load_go, save_go, auto_fire, at_end;

  assign mount_rise = img_mounted & ~mounted_q;
  assign save_rise  = save_req & ~save_req_q;
  assign dl_rise    = download & ~download_q;
  assign ack_rise   = sd_ack & ~ack_q;
  assign ack_fall   = ~sd_ack & ack_q;

  // Sector count = ceil(size / 512), clamped to the dpram capacity.
  assign img_sectors = {1'b0, img_size[31:9]} + {23'd0, |img_size[8:0]};
  assign img_valid   = (img_size != 32'd0);

  always_comb begin
    img_last = '1;
    if (img_sectors < 24'(MaxSectors)) img_last = SECTORS_W'(img_sectors - 24'd1);
  end

  assign auto_fire = (AUTOSAVE_CYCLES != 0) && dirty_q && (state_q == StIdle) && !nvram_we &&
                     (timer_q == TIMER_W'(1));

  // A mount edge always beats a save trigger in the same cycle.
  assign load_go = (state_q == StIdle) && !dl_rise &&
                   ((mount_rise && img_valid) || load_pend_q);
  assign save_go = (state_q == StIdle) && !load_go && !mount_rise && !dl_rise &&
                   (save_rise || pend_q || auto_fire) && bk_ena_q && !img_readonly;

  assign at_end = (lba_q == last_q) || abort_q;

  always_ff @(posedge clk_sys or negedge RESET_n) begin
    if (!RESET_n) state_q <= StIdle;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (load_go || save_go) state_d = StStart;
      StStart: state_d = abort_q ? StDone : StReq;
      StReq:   state_d = abort_q ? StDone : StXfer;
      StXfer:  if (ack_fall) state_d = at_end ? StDone : StReq;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    busy        = (state_q != StIdle);
    lba_d       = lba_q;
    last_d      = last_q;
    load_mode_d = load_mode_q;
    abort_d     = abort_q;
    pend_d      = pend_q;
    load_pend_d = load_pend_q;
    dirty_d     = dirty_q;
    bk_ena_d    = bk_ena_q;
    rd_d        = rd_q;
    wr_d        = wr_q;
    bk_reset_d  = 1'b0;
    timer_d     = timer_q;

    if (busy && save_rise) pend_d = 1'b1;

    // A new image replaces whatever is running; the in-flight sector still completes.
    if (mount_rise) begin
      bk_ena_d = img_valid;
      if (img_valid) last_d = img_last;
      if (busy) begin
        abort_d     = 1'b1;
        load_pend_d = img_valid;
      end
    end

    unique case (state_q)
      StIdle: begin
        pend_d      = 1'b0;
        load_pend_d = 1'b0;
        if (load_go)      load_mode_d = 1'b1;
        else if (save_go) load_mode_d = 1'b0;
      end
      StStart: begin
        lba_d   = '0;
        dirty_d = 1'b0;
      end
      StReq: begin
        if (!abort_q) begin
          rd_d = load_mode_q;
          wr_d = ~load_mode_q;
        end
      end
      StXfer: begin
        if (ack_rise) begin
          rd_d = 1'b0;
          wr_d = 1'b0;
        end
        if (ack_fall && !at_end) lba_d = lba_q + SECTORS_W'(1);
      end
      StDone: begin
        bk_reset_d = load_mode_q & ~abort_q;
        abort_d    = 1'b0;
      end
      default: ;
    endcase

    // Writes during a save land after the START clear so the next save is still requested.
    if (nvram_we && bk_ena_q && !(busy && load_mode_q)) dirty_d = 1'b1;

    if (dl_rise) begin
      bk_ena_d    = 1'b0;
      pend_d      = 1'b0;
      load_pend_d = 1'b0;
      dirty_d     = 1'b0;
      if (busy && state_q != StDone) abort_d = 1'b1;
    end

    if (AUTOSAVE_CYCLES != 0) begin
      if (nvram_we) begin
        timer_d = TIMER_W'(AUTOSAVE_CYCLES);
      end else if (dirty_q && !busy && timer_q != '0) begin
        timer_d = timer_q - TIMER_W'(1);
      end
    end
  end

  always_ff @(posedge clk_sys or negedge RESET_n) begin
    if (!RESET_n) begin
      mounted_q   <= 1'b0;
      save_req_q  <= 1'b0;
      download_q  <= 1'b0;
      ack_q       <= 1'b0;
      lba_q       <= '0;
      last_q      <= '0;
      load_mode_q <= 1'b0;
      abort_q     <= 1'b0;
      pend_q      <= 1'b0;
      load_pend_q <= 1'b0;
      dirty_q     <= 1'b0;
      bk_ena_q    <= 1'b0;
      rd_q        <= 1'b0;
      wr_q        <= 1'b0;
      bk_reset_q  <= 1'b0;
      timer_q     <= '0;
    end else begin
      mounted_q   <= img_mounted;
      save_req_q  <= save_req;
      download_q  <= download;
      ack_q       <= sd_ack;
      lba_q       <= lba_d;
      last_q      <= last_d;
      load_mode_q <= load_mode_d;
      abort_q     <= abort_d;
      pend_q      <= pend_d;
      load_pend_q <= load_pend_d;
      dirty_q     <= dirty_d;
      bk_ena_q    <= bk_ena_d;
      rd_q        <= rd_d;
      wr_q        <= wr_d;
      bk_reset_q  <= bk_reset_d;
      timer_q     <= timer_d;
    end
  end

  assign sd_lba     = 32'(lba_q);
  assign buf_sector = lba_q;
  assign sd_rd      = rd_q;
  assign sd_wr      = wr_q;
  assign bk_ena     = bk_ena_q;
  assign dirty      = dirty_q;
  assign bk_reset   = bk_reset_q;

endmodule
